// File: rtl/probe_box.sv
// Framebuffer collision probe: scans a size x size square column-major through a
// 1-cycle-latency pixel memory and reports the first pixel that is not background.
module probe_box #(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         SIZE_W    = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic [7:0]        x_in,
    input  logic [6:0]        y_in,
    input  logic [SIZE_W-1:0] size,
    output logic              rd_en,
    output logic [7:0]        x_rd,
    output logic [6:0]        y_rd,
    input  logic [2:0]        rd_colour,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [7:0]        hit_x,
    output logic [6:0]        hit_y
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

    state_t            r_state;
    logic [7:0]        r_xBase;
    logic [6:0]        r_yBase;
    logic [SIZE_W-1:0] r_size;
    logic [SIZE_W-1:0] r_cx;
    logic [SIZE_W-1:0] r_cy;
    logic              r_pend;
    logic [7:0]        r_shX;
    logic [6:0]        r_shY;
    logic              r_rdEn;
    logic [7:0]        r_xRd;
    logic [6:0]        r_yRd;
    logic              r_busy;
    logic              r_done;
    logic              r_hit;
    logic [7:0]        r_hitX;
    logic [6:0]        r_hitY;

    logic              w_hitNow;
    logic              w_lastRow;
    logic              w_lastCol;
    logic [SIZE_W-1:0] w_nextCx;
    logic [SIZE_W-1:0] w_nextCy;

    // Data on rd_colour belongs to the read issued last cycle, tracked by r_pend/r_sh*.
    assign w_hitNow  = r_pend && (rd_colour != BG_COLOUR);
    assign w_lastRow = (r_cy == r_size - ONE);
    assign w_lastCol = (r_cx == r_size - ONE);
    assign w_nextCy  = w_lastRow ? '0 : r_cy + ONE;
    assign w_nextCx  = w_lastRow ? r_cx + ONE : r_cx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_xBase <= '0;
            r_yBase <= '0;
            r_size  <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_pend  <= 1'b0;
            r_shX   <= '0;
            r_shY   <= '0;
            r_rdEn  <= 1'b0;
            r_xRd   <= '0;
            r_yRd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hit   <= 1'b0;
            r_hitX  <= '0;
            r_hitY  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_xBase <= x_in;
                        r_yBase <= y_in;
                        r_size  <= size;
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_pend  <= 1'b0;
                        r_hit   <= 1'b0;
                        r_hitX  <= '0;
                        r_hitY  <= '0;
                        if (size == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= READ;
                            r_busy  <= 1'b1;
                            r_rdEn  <= 1'b1;
                            r_xRd   <= x_in;
                            r_yRd   <= y_in;
                        end
                    end
                end
                READ: begin
                    r_pend <= 1'b1;
                    r_shX  <= r_xRd;
                    r_shY  <= r_yRd;
                    // A hit abandons the read issued this cycle; its data is never compared.
                    if (w_hitNow) begin
                        r_hit   <= 1'b1;
                        r_hitX  <= r_shX;
                        r_hitY  <= r_shY;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pend  <= 1'b0;
                        r_rdEn  <= 1'b0;
                        r_xRd   <= '0;
                        r_yRd   <= '0;
                    end else if (w_lastCol && w_lastRow) begin
                        r_state <= DRAIN;
                        r_rdEn  <= 1'b0;
                        r_xRd   <= '0;
                        r_yRd   <= '0;
                    end else begin
                        r_cx  <= w_nextCx;
                        r_cy  <= w_nextCy;
                        r_xRd <= r_xBase + 8'(w_nextCx);
                        r_yRd <= r_yBase + 7'(w_nextCy);
                    end
                end
                DRAIN: begin
                    if (w_hitNow) begin
                        r_hit  <= 1'b1;
                        r_hitX <= r_shX;
                        r_hitY <= r_shY;
                    end
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_pend  <= 1'b0;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_pend  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_en = r_rdEn;
    assign x_rd  = r_xRd;
    assign y_rd  = r_yRd;
    assign busy  = r_busy;
    assign done  = r_done;
    assign hit   = r_hit;
    assign hit_x = r_hitX;
    assign hit_y = r_hitY;

endmodule

// File: tb/tb_probe_box.sv
// Self-checking bench for probe_box: directed vector table, hand-written reset and
// busy-go sequences, and randomized scans checked against a pixel-memory model.
module tb_probe_box;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       go = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [6:0] size = '0;
    logic       rd_en;
    logic [7:0] x_rd;
    logic [6:0] y_rd;
    logic [2:0] rd_colour;
    logic       busy;
    logic       done;
    logic       hit;
    logic [7:0] hit_x;
    logic [6:0] hit_y;

    int testsRun = 0;
    int testsFailed = 0;

    logic [2:0] mem [256][128];

    probe_box #(.BG_COLOUR(3'b000), .SIZE_W(7)) dut (
        .clk(clk), .resetn(resetn), .go(go), .x_in(x_in), .y_in(y_in), .size(size),
        .rd_en(rd_en), .x_rd(x_rd), .y_rd(y_rd), .rd_colour(rd_colour),
        .busy(busy), .done(done), .hit(hit), .hit_x(hit_x), .hit_y(hit_y)
    );

    always #5 clk = ~clk;

    // Pixel memory with one cycle of latency; idle cycles return junk colours.
    always @(posedge clk) begin
        if (rd_en) rd_colour <= mem[x_rd][y_rd];
        else       rd_colour <= 3'($urandom_range(1, 7));
    end

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [6:0] sz;
        int         plantX;
        int         plantY;
        logic [2:0] col;
        logic       eHit;
        logic [7:0] eHx;
        logic [6:0] eHy;
        int         eDone;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clearMem();
        for (int xi = 0; xi < 256; xi++)
            for (int yi = 0; yi < 128; yi++)
                mem[xi][yi] = 3'b000;
    endtask

    // Reference: walk the square column-major, first non-background pixel wins.
    function automatic void refModel(input logic [7:0] xs, input logic [6:0] ys, input int n,
                                     output logic h, output logic [7:0] hx,
                                     output logic [6:0] hy, output int dc);
        logic [7:0] ax;
        logic [6:0] ay;
        h  = 1'b0;
        hx = '0;
        hy = '0;
        dc = (n == 0) ? 1 : n * n + 2;
        for (int i = 0; i < n * n; i++) begin
            if (!h) begin
                ax = xs + 8'(i / n);
                ay = ys + 7'(i % n);
                if (mem[ax][ay] != 3'b000) begin
                    h  = 1'b1;
                    hx = ax;
                    hy = ay;
                    dc = i + 3;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] xs, input logic [6:0] ys, input logic [6:0] sz,
                                 input int goAgainAt, input logic eHit, input logic [7:0] eHx,
                                 input logic [6:0] eHy, input int eDone);
        int n, total, expReads, reads, doneAt, busyCnt, badAddr, c;
        logic [7:0] ex;
        logic [6:0] ey;
        n = int'(sz);
        total = n * n;
        expReads = (eDone - 1 < total) ? eDone - 1 : total;
        reads = 0; doneAt = 0; busyCnt = 0; badAddr = 0;
        @(negedge clk);
        x_in = xs; y_in = ys; size = sz; go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        c = 1;
        while (doneAt == 0 && c <= total + 10) begin
            if (c == 1) checkOutput("hitClearedAtGo", longint'(hit), 0);
            if (rd_en) begin
                if (reads < expReads) begin
                    ex = xs + 8'(reads / n);
                    ey = ys + 7'(reads % n);
                    if (x_rd !== ex || y_rd !== ey) begin
                        if (badAddr == 0)
                            $display("[TB] read %0d at (%0d,%0d), wanted (%0d,%0d)", reads, x_rd, y_rd, ex, ey);
                        badAddr++;
                    end
                end
                reads++;
            end
            if (busy) busyCnt++;
            if (done) doneAt = c;
            else begin
                if (c == goAgainAt) begin
                    go = 1'b1; x_in = ~xs; y_in = ~ys; size = sz + 7'd1;
                end
                @(posedge clk);
                #1 go = 1'b0;
                c++;
            end
        end
        x_in = xs; y_in = ys; size = sz;
        checkOutput("doneCycle", doneAt, eDone);
        checkOutput("readCount", reads, expReads);
        checkOutput("badAddresses", badAddr, 0);
        checkOutput("busyCycles", busyCnt, eDone - 1);
        checkOutput("hit", longint'(hit), longint'(eHit));
        checkOutput("hitX", longint'(hit_x), longint'(eHx));
        checkOutput("hitY", longint'(hit_y), longint'(eHy));
        @(posedge clk);
        #1;
        checkOutput("donePulseWidth", longint'(done), 0);
        checkOutput("hitHeld", longint'({hit, hit_x, hit_y}), longint'({eHit, eHx, eHy}));
    endtask

    function automatic longint allOutputs();
        return longint'({rd_en, x_rd, y_rd, busy, done, hit, hit_x, hit_y});
    endfunction

    initial begin
        logic       mh;
        logic [7:0] mhx;
        logic [6:0] mhy;
        int         mdc;
        int         nPlant;
        logic [7:0] rx;
        logic [6:0] ry;
        logic [6:0] rs;

        vecs.push_back('{8'd5,   7'd5,   7'd0, -1,  -1,  3'd0, 1'b0, 8'd0,   7'd0,   1});
        vecs.push_back('{8'd10,  7'd20,  7'd3, -1,  -1,  3'd0, 1'b0, 8'd0,   7'd0,   11});
        vecs.push_back('{8'd10,  7'd20,  7'd3, 11,  22,  3'd4, 1'b1, 8'd11,  7'd22,  8});
        vecs.push_back('{8'd254, 7'd126, 7'd4, -1,  -1,  3'd0, 1'b0, 8'd0,   7'd0,   18});
        vecs.push_back('{8'd254, 7'd126, 7'd4, 1,   127, 3'd1, 1'b1, 8'd1,   7'd127, 16});
        vecs.push_back('{8'd0,   7'd0,   7'd1, 0,   0,   3'd7, 1'b1, 8'd0,   7'd0,   3});
        vecs.push_back('{8'd100, 7'd50,  7'd2, 101, 51,  3'd2, 1'b1, 8'd101, 7'd51,  6});
        vecs.push_back('{8'd10,  7'd20,  7'd3, 9,   20,  3'd5, 1'b0, 8'd0,   7'd0,   11});

        clearMem();
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput("resetState", allOutputs(), 0);
        @(negedge clk) resetn = 1'b1;

        foreach (vecs[i]) begin
            clearMem();
            if (vecs[i].plantX >= 0) mem[vecs[i].plantX][vecs[i].plantY] = vecs[i].col;
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].sz, 0,
                          vecs[i].eHit, vecs[i].eHx, vecs[i].eHy, vecs[i].eDone);
        end

        // go asserted mid-scan with different operands must be ignored
        clearMem();
        applyStimulus(8'd10, 7'd20, 7'd3, 4, 1'b0, 8'd0, 7'd0, 11);
        mem[11][22] = 3'd4;
        applyStimulus(8'd10, 7'd20, 7'd3, 3, 1'b1, 8'd11, 7'd22, 8);

        // reset while idle clears a held hit
        @(negedge clk) resetn = 1'b0;
        #1 checkOutput("resetClearsHit", allOutputs(), 0);
        @(negedge clk) resetn = 1'b1;

        // reset in cycle 4 of a size-5 scan
        clearMem();
        @(negedge clk);
        x_in = 8'd3; y_in = 7'd4; size = 7'd5; go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (3) @(posedge clk);
        #2 checkOutput("busyBeforeReset", longint'({busy, rd_en}), 3);
        resetn = 1'b0;
        #1 checkOutput("midScanReset", allOutputs(), 0);
        @(negedge clk) resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkOutput("idleAfterReset", allOutputs(), 0);
        mem[4][7] = 3'd6;
        applyStimulus(8'd3, 7'd4, 7'd5, 0, 1'b1, 8'd4, 7'd7, 11);

        // randomized scans against the reference model
        for (int t = 0; t < 25; t++) begin
            clearMem();
            rx = 8'($urandom);
            ry = 7'($urandom);
            rs = 7'($urandom_range(0, 6));
            nPlant = $urandom_range(0, 3);
            for (int p = 0; p < nPlant; p++)
                mem[8'(rx + 8'($urandom_range(0, 7)))][7'(ry + 7'($urandom_range(0, 7)))] =
                    3'($urandom_range(1, 7));
            refModel(rx, ry, int'(rs), mh, mhx, mhy, mdc);
            applyStimulus(rx, ry, rs, ($urandom_range(0, 2) == 0) ? 2 : 0, mh, mhx, mhy, mdc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/probe_box.md
Name: probe_box

Overview:
Framebuffer reader that scans a size x size square of pixels and reports whether any pixel differs from the background colour. It reads the same square region the ball/brick drawer writes, and game logic uses it for collision probing before a move. It issues one read per cycle to a 1-cycle-latency pixel memory and stops on the first hit.

Parameters:
BG_COLOUR, 3'b000, background colour; any other returned colour is a hit.
SIZE_W, 7, width of the size input and of the internal column/row counters.

Ports:
clk  input  1  system clock, rising-edge.
resetn  input  1  asynchronous, active-low reset.
go  input  1  start request; sampled only in IDLE.
x_in  input  8  left column of the square.
y_in  input  7  top row of the square.
size  input  SIZE_W  edge length in pixels; 0 is legal.
rd_en  output  1  pixel read strobe.
x_rd  output  8  read column address.
y_rd  output  7  read row address.
rd_colour  input  3  pixel data; valid the cycle after rd_en.
busy  output  1  high in READ and DRAIN.
done  output  1  one-cycle pulse at the end of every scan.
hit  output  1  a non-background pixel was found; held until the next accepted go.
hit_x  output  8  column of the first hit; 0 when hit=0.
hit_y  output  7  row of the first hit; 0 when hit=0.

Behaviour:
- Reset: asserting resetn low takes effect immediately, at any time, including mid-scan.
  - State goes to IDLE.
  - rd_en, x_rd, y_rd, busy, done, hit, hit_x, hit_y, all counters and the pending flag go to 0.
- States:
  - IDLE: wait for go.
  - READ: issue one read per cycle.
  - DRAIN: consume the last read's data.
  - DONE: pulse done.
- IDLE, go=1 at a clock edge:
  - Latch x_in, y_in and size.
  - Clear hit, hit_x and hit_y; zero cx and cy.
  - Next state is READ, or DONE if size==0.
- IDLE, go=0: stay in IDLE.
- go asserted in any state other than IDLE is ignored; latched operands do not change.
- READ, every cycle:
  - rd_en=1, x_rd = x_base+cx, y_rd = y_base+cy.
  - Sums are truncated to 8 and 7 bits, so addresses wrap modulo 256 and 128.
- Scan order is column-major:
  - cy increments 0..size-1.
  - On cy==size-1, cy returns to 0 and cx increments.
- Issuing the address with cx==size-1 and cy==size-1 moves the state to DRAIN.
- Pending pipeline:
  - Each issued read sets pending=1 and stores its x_rd/y_rd in a shadow register.
  - On the next cycle, if pending and rd_colour != BG_COLOUR, a hit is detected.
- On a hit detected in READ or DRAIN:
  - Set hit=1 and copy the shadow address into hit_x/hit_y.
  - Next state is DONE.
  - The read issued in the detection cycle is discarded; its data is never compared.
- DRAIN: rd_en=0; compare the final read's data; next state is DONE.
- DONE: done=1 for exactly one cycle, busy=0, pending cleared; next state is IDLE.
- hit, hit_x and hit_y stay stable from DONE until the next accepted go.
- Timing, no hit, size N>0, go accepted at edge 0:
  - READ occupies cycles 1..N*N.
  - DRAIN is cycle N*N+1.
  - done is high in cycle N*N+2.
  - There are exactly N*N rd_en cycles.
- Timing, first hit on read index k (1-based, issued in cycle k): detection in cycle k+1, done high in cycle k+2.
- size==0: no rd_en, done high in cycle 1, hit=0.

Test Plan:
- Size 0: size=0, go pulse -> no rd_en; done in cycle 1; hit=0; busy never high.
- All background: x_in=10, y_in=20, size=3, memory all BG -> 9 reads (10,20),(10,21),(10,22),(11,20)...(12,22); done in cycle 11; hit=0, hit_x=0.
- Mid-scan hit: as above, with colour 3'b100 only at (11,22) (read index 6) -> 7 rd_en cycles; detection in cycle 7; done in cycle 8; hit=1, hit_x=11, hit_y=22.
- Wrap: x_in=254, y_in=126, size=4, all BG -> x_rd sequence 254,255,0,1; y_rd 126,127,0,1; done in cycle 18.
- Reset and busy-go: assert go again during READ -> ignored, scan completes normally. Then drive resetn low in cycle 4 of a size-5 scan -> all outputs 0 the same cycle; after release, state is IDLE and a new go starts a clean scan.
